// File: rtl/div32_seq.sv
// rtl/div32_seq.sv - sequential restoring shift-subtract integer divider
//
// Purpose:
//   Divides dividend by divisor one quotient bit per clock using restoring
//   trial subtraction. A start/busy/done handshake lets the controller issue
//   a division and collect the quotient and remainder WIDTH+1 cycles later.
//   A zero divisor short-circuits to a one-cycle completion with
//   quotient = all-ones, remainder = dividend and div_by_zero = 1.
//
// Configuration macro:
//   DIV32_SIGNED_EN - when defined, is_signed=1 selects two's-complement
//                     division (truncation toward zero, remainder takes the
//                     dividend's sign). When undefined, is_signed is ignored
//                     and no sign logic is built. Latency is identical.
//
// Ports:
//   clk          in   1      clock, rising edge
//   rst          in   1      synchronous active-high reset
//   start        in   1      request a division, sampled only while busy=0
//   dividend     in   WIDTH  numerator, captured on accepted start
//   divisor      in   WIDTH  denominator, captured on accepted start
//   is_signed    in   1      two's-complement mode select (signed build only)
//   busy         out  1      operation in progress or completing
//   done         out  1      one-cycle pulse, results valid from this cycle
//   quotient     out  WIDTH  registered quotient
//   remainder    out  WIDTH  registered remainder
//   div_by_zero  out  1      captured divisor was zero

module div32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   prem_q, prem_d;     // partial remainder R
    logic [WIDTH-1:0] shq_q, shq_d;       // dividend/quotient shift register Q
    logic [WIDTH-1:0] dsr_q, dsr_d;       // divisor magnitude D
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] mag_dividend;
    logic [WIDTH-1:0] mag_divisor;

    // One restoring iteration, evaluated combinationally from the current state.
    logic [WIDTH:0]   prem_shift;
    logic [WIDTH:0]   trial;
    logic             q_bit;
    logic [WIDTH:0]   prem_next;
    logic [WIDTH-1:0] shq_next;
    logic [WIDTH-1:0] quo_final;
    logic [WIDTH-1:0] rmd_final;

`ifdef DIV32_SIGNED_EN
    logic neg_quo_q, neg_quo_d;
    logic neg_rmd_q, neg_rmd_d;
    logic dividend_neg;
    logic divisor_neg;

    // Magnitudes are taken at capture; -2^(WIDTH-1) maps to itself, which is
    // the correct unsigned magnitude, so the overflow case needs no special path.
    assign dividend_neg = is_signed & dividend[WIDTH-1];
    assign divisor_neg  = is_signed & divisor[WIDTH-1];
    assign mag_dividend = dividend_neg ? -dividend : dividend;
    assign mag_divisor  = divisor_neg  ? -divisor  : divisor;
`else
    logic unused_is_signed;

    assign unused_is_signed = is_signed;
    assign mag_dividend     = dividend;
    assign mag_divisor      = divisor;
`endif

    assign prem_shift = {prem_q[WIDTH-1:0], shq_q[WIDTH-1]};
    assign trial      = prem_shift - {1'b0, dsr_q};
    // A clear borrow bit means the trial subtraction fit: keep it and emit a 1.
    assign q_bit      = ~trial[WIDTH];
    assign prem_next  = q_bit ? trial : prem_shift;
    assign shq_next   = {shq_q[WIDTH-2:0], q_bit};

`ifdef DIV32_SIGNED_EN
    assign quo_final = neg_quo_q ? -shq_next : shq_next;
    assign rmd_final = neg_rmd_q ? -prem_next[WIDTH-1:0] : prem_next[WIDTH-1:0];
`else
    assign quo_final = shq_next;
    assign rmd_final = prem_next[WIDTH-1:0];
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        shq_d   = shq_q;
        dsr_d   = dsr_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
`ifdef DIV32_SIGNED_EN
        neg_quo_d = neg_quo_q;
        neg_rmd_d = neg_rmd_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d  = '0;
                    prem_d = '0;
                    shq_d  = mag_dividend;
                    dsr_d  = mag_divisor;
`ifdef DIV32_SIGNED_EN
                    neg_quo_d = dividend_neg ^ divisor_neg;
                    neg_rmd_d = dividend_neg;
`endif
                    if (divisor == '0) begin
                        // Zero divisor completes immediately; results are
                        // loaded now so they are visible in the done cycle.
                        state_d = S_FIN;
                        quo_d   = '1;
                        rmd_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        quo_d   = '0;
                        rmd_d   = '0;
                        dbz_d   = 1'b0;
                    end
                end
            end

            S_RUN: begin
                prem_d = prem_next;
                shq_d  = shq_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    // Final iteration writes the results straight from the
                    // combinational step so they are valid on entry to FIN.
                    state_d = S_FIN;
                    quo_d   = quo_final;
                    rmd_d   = rmd_final;
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            shq_q   <= '0;
            dsr_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef DIV32_SIGNED_EN
            neg_quo_q <= 1'b0;
            neg_rmd_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            shq_q   <= shq_d;
            dsr_q   <= dsr_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
`ifdef DIV32_SIGNED_EN
            neg_quo_q <= neg_quo_d;
            neg_rmd_q <= neg_rmd_d;
`endif
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_FIN);
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div32_seq.sv
// tb/tb_div32_seq.sv - self-checking bench for div32_seq against a behavioural model

module tb_div32_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    always #5 clk = ~clk;

    div32_seq #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .is_signed(is_signed),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Arithmetic reference: returns {quotient, remainder}.
    function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic s);
        logic [W-1:0] q;
        logic [W-1:0] r;
        if (b == '0) begin
            q = '1;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
`ifdef DIV32_SIGNED_EN
            if (s) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    q = 32'h8000_0000;
                    r = '0;
                end else begin
                    q = $signed(a) / $signed(b);
                    r = $signed(a) % $signed(b);
                end
            end
`else
            if (s) begin
                q = a / b;
            end
`endif
        end
        return {q, r};
    endfunction

    // Cycle-level protocol model: counts cycles left until the operation ends.
    int           left = 0;
    logic         chk_en = 1'b0;
    logic         exp_busy = 1'b0;
    logic         exp_done = 1'b0;
    logic [W-1:0] exp_q = '0;
    logic [W-1:0] exp_r = '0;
    logic         exp_z = 1'b0;
    logic [W-1:0] pend_q = '0;
    logic [W-1:0] pend_r = '0;
    logic         pend_z = 1'b0;

    always @(posedge clk) begin : model
        logic [2*W-1:0] res;
        logic           accept;
        int             nleft;
        res    = ref_div(dividend, divisor, is_signed);
        accept = start && (left == 0);
        chk_en <= 1'b1;
        if (rst) begin
            left     <= 0;
            exp_busy <= 1'b0;
            exp_done <= 1'b0;
            exp_q    <= '0;
            exp_r    <= '0;
            exp_z    <= 1'b0;
        end else begin
            if (accept) nleft = (divisor == '0) ? 1 : W + 1;
            else if (left > 0) nleft = left - 1;
            else nleft = 0;
            left     <= nleft;
            exp_busy <= (nleft > 0);
            exp_done <= (nleft == 1);
            if (accept) begin
                pend_q <= res[2*W-1:W];
                pend_r <= res[W-1:0];
                pend_z <= (divisor == '0);
            end
            if (nleft == 1) begin
                exp_q <= accept ? res[2*W-1:W] : pend_q;
                exp_r <= accept ? res[W-1:0] : pend_r;
                exp_z <= accept ? (divisor == '0) : pend_z;
            end else if (accept) begin
                exp_q <= '0;
                exp_r <= '0;
                exp_z <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", W'(busy), W'(exp_busy));
            chk("done", W'(done), W'(exp_done));
            chk("quotient", quotient, exp_q);
            chk("remainder", remainder, exp_r);
            chk("div_by_zero", W'(div_by_zero), W'(exp_z));
        end
    end

    task automatic cycle_();
        @(posedge clk);
        #1;
    endtask

    // Issue one division from idle, wait for done and check literal results and latency.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
        int k;
        dividend  = a;
        divisor   = b;
        is_signed = s;
        start     = 1'b1;
        cycle_();
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        k = 1;
        while (!done && k < W + 4) begin
            cycle_();
            k++;
        end
        chk("latency", W'(k), (b == '0) ? W'(1) : W'(W + 1));
        chk("lit_quotient", quotient, eq);
        chk("lit_remainder", remainder, er);
        chk("lit_div_by_zero", W'(div_by_zero), W'(ez));
        cycle_();
    endtask

    function automatic logic [W-1:0] rnd_op();
        unique case ($urandom_range(0, 6))
            0: return '0;
            1: return W'($urandom_range(1, 15));
            2: return '1;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF - W'($urandom_range(0, 15));
            5: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [2*W-1:0] p;
        int k;

        // Literal pins of the reference model.
        p = ref_div(32'd100, 32'd7, 1'b0);
        chk("pin_100_7", p[2*W-1:W] ^ p[W-1:0], 32'd14 ^ 32'd2);
        chk("pin_100_7_q", p[2*W-1:W], 32'd14);
        p = ref_div(32'h1234_5678, 32'd0, 1'b0);
        chk("pin_dbz_r", p[W-1:0], 32'h1234_5678);
        p = ref_div(32'hFFFF_FFFF, 32'd1, 1'b0);
        chk("pin_max_q", p[2*W-1:W], 32'hFFFF_FFFF);
`ifdef DIV32_SIGNED_EN
        p = ref_div(32'hFFFF_FFF9, 32'd2, 1'b1);
        chk("pin_sgn_q", p[2*W-1:W], 32'hFFFF_FFFD);
        chk("pin_sgn_r", p[W-1:0], 32'hFFFF_FFFF);
`else
        p = ref_div(32'hFFFF_FFF9, 32'd2, 1'b1);
        chk("pin_uns_q", p[2*W-1:W], 32'h7FFF_FFFC);
        chk("pin_uns_r", p[W-1:0], 32'd1);
`endif

        rst = 1'b1;
        repeat (3) cycle_();
        rst = 1'b0;
        repeat (10) cycle_();

        issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        issue(32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        issue(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);
        issue(32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0);
        issue(32'h8000_0000, 32'h8000_0000, 1'b0, 32'd1, 32'd0, 1'b0);
`ifdef DIV32_SIGNED_EN
        issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        issue(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
        issue(32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
`else
        issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0);
`endif

        // start while busy (cycle 5) and during the done cycle are ignored.
        dividend = 32'd1000;
        divisor  = 32'd3;
        start    = 1'b1;
        cycle_();
        start = 1'b0;
        repeat (4) cycle_();
        dividend = 32'd77;
        divisor  = 32'd5;
        start    = 1'b1;
        cycle_();
        start = 1'b0;
        k = 6;
        while (!done && k < W + 4) begin
            cycle_();
            k++;
        end
        chk("busy_ignore_latency", W'(k), W'(W + 1));
        chk("busy_ignore_q", quotient, 32'd333);
        dividend = 32'd9;
        divisor  = 32'd2;
        start    = 1'b1;
        cycle_();
        start = 1'b0;
        chk("fin_ignore_busy", W'(busy), W'(0));
        chk("fin_ignore_q", quotient, 32'd333);
        chk("fin_ignore_r", remainder, 32'd1);
        cycle_();

        // Reset in cycle 10 of a run aborts it; start in cycle 12 completes in cycle 45.
        dividend = 32'd12345;
        divisor  = 32'd11;
        start    = 1'b1;
        cycle_();
        start = 1'b0;
        repeat (9) cycle_();
        rst = 1'b1;
        cycle_();
        rst = 1'b0;
        chk("abort_busy", W'(busy), W'(0));
        chk("abort_q", quotient, 32'd0);
        cycle_();
        issue(32'd12345, 32'd11, 1'b0, 32'd1122, 32'd3, 1'b0);

        // Random traffic, including starts while busy and occasional resets.
        for (int i = 0; i < 6000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            start     = ($urandom_range(0, 2) == 0);
            dividend  = rnd_op();
            divisor   = rnd_op();
            is_signed = $urandom_range(0, 1) == 1;
            cycle_();
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (W + 4) cycle_();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/div32_seq.md
# div32_seq

Sequential 32-bit integer divider for the PE datapath. It is the inverse of the PE's 32-bit ripple adder: repeated trial subtraction instead of addition. It uses a restoring shift-subtract algorithm and produces one quotient bit per clock. A start/busy/done handshake lets the PE controller issue a division and collect quotient and remainder a fixed number of cycles later.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width; iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request a division; sampled only when `busy`=0.
- `dividend`  in  WIDTH  numerator, captured on accepted `start`.
- `divisor`  in  WIDTH  denominator, captured on accepted `start`.
- `is_signed`  in  1  two's-complement mode select, captured on accepted `start`; effective only with `DIV32_SIGNED_EN`.
- `busy`  out  1  high while a division is in progress or completing.
- `done`  out  1  one-cycle pulse; results valid from this cycle.
- `quotient`  out  WIDTH  registered quotient, held until next accepted `start`.
- `remainder`  out  WIDTH  registered remainder, held until next accepted `start`.
- `div_by_zero`  out  1  set with `done` when captured divisor was 0; held with results.

## Operation
- FSM states: IDLE, RUN, FIN.
- IDLE → RUN when `start`=1 and divisor≠0. IDLE → FIN when `start`=1 and divisor=0. Otherwise stay in IDLE.
- RUN is `WIDTH` cycles, counted by a `$clog2(WIDTH)+1`-bit counter from 0. RUN → FIN after iteration `WIDTH-1`.
- FIN → IDLE unconditionally after one cycle.
- `busy` = (state≠IDLE). `done` = (state==FIN).
- Accepted `start` captures the operands:
  - Partial remainder R (WIDTH+1 bits) cleared.
  - Shift register Q loaded with |dividend|.
  - Divisor D loaded with |divisor|.
  - `quotient`, `remainder` and `div_by_zero` cleared.
- Each RUN cycle:
  - R' = {R[WIDTH-1:0], Q[WIDTH-1]}.
  - T = R' − {0,D}, computed at WIDTH+1 bits.
  - If T[WIDTH]=0: R←T and shift 1 into Q LSB. Else: R←R' and shift 0 into Q LSB.
- Entry to FIN: `quotient`←Q and `remainder`←R[WIDTH-1:0], with sign fix-up applied in signed mode.
- Divide-by-zero (FIN reached direct from IDLE): `quotient`=all-ones, `remainder`=dividend unchanged, `div_by_zero`=1.
- `start` while `busy`=1 is ignored; the in-flight operation is unaffected.
- `start` in the FIN cycle is ignored because `busy`=1.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, counter=0.
- `rst` asserted at any time, including mid-RUN, aborts the operation. All reset values apply at the next edge, and no `done` is produced.
- `rst` has priority over `start` in the same cycle.
- Normal latency, with `start` accepted in cycle 0:
  - `busy`=1 in cycles 1..WIDTH+1.
  - `done`=1 in cycle WIDTH+1 (33 for default).
  - Next `start` accepted in cycle WIDTH+2.
- Divide-by-zero latency: `busy`=1 and `done`=1 both in cycle 1. Next `start` accepted in cycle 2.
- Sustained throughput: one division per WIDTH+2 cycles.
- Outputs hold their value from `done` until the cycle after the next accepted `start`.

## Configuration
- `DIV32_SIGNED_EN` defined: `is_signed`=1 selects two's-complement division.
  - Operands are converted to magnitudes at capture.
  - Quotient is negated if the operand signs differ; it truncates toward zero.
  - Remainder takes the dividend's sign.
  - Overflow case −2^(WIDTH−1) / −1 gives `quotient`=0x80000000, `remainder`=0, with normal latency and `div_by_zero`=0.
  - Divide-by-zero gives `quotient`=all-ones, `remainder`=dividend.
- `DIV32_SIGNED_EN` undefined: `is_signed` is ignored, all operations are unsigned, and no sign logic is synthesized. Latency is identical in both builds.

## Test plan
- Reset then idle: all outputs 0 for 10 cycles, `busy`=0.
- Unsigned 100 / 7: `start` in cycle 0 → `done` pulse in cycle 33 only, `quotient`=14, `remainder`=2, `div_by_zero`=0.
- Divide-by-zero, 0x12345678 / 0: `done` in cycle 1, `quotient`=0xFFFFFFFF, `remainder`=0x12345678, `div_by_zero`=1.
- Boundaries:
  - 0xFFFFFFFF / 1 → q=0xFFFFFFFF, r=0.
  - 5 / 9 → q=0, r=5.
  - 0x80000000 / 0x80000000 → q=1, r=0.
- Protocol:
  - `start` with new operands in cycles 5 and 33 → both ignored; first result unchanged.
  - `rst` in cycle 10 of a RUN → no `done`, outputs 0.
  - `start` in cycle 12 → correct result in cycle 45.
- Signed (macro defined, `is_signed`=1):
  - −7 / 2 → q=−3 (0xFFFFFFFD), r=−1.
  - 7 / −2 → q=−3, r=1.
  - 0x80000000 / −1 → q=0x80000000, r=0.
  - Macro undefined: −7 / 2 is treated as unsigned, giving q=0x7FFFFFFC, r=1.
